// File: rtl/beat_envelope_gen.sv
// beat_envelope_gen: one shared attack/hold/release envelope that
// drives N_CH scaled parameter channels between run-time min/max.
module beat_envelope_gen #(
  parameter int N_CH         = 2,
  parameter int VAL_W        = 8,
  parameter int STEP_CLKS    = 50_000,
  parameter int ATTACK_LOG2  = 6,
  parameter int HOLD_STEPS   = 0,
  parameter int RELEASE_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  beat_trigger,
  input  logic [VAL_W-1:0]      beat_level,
  input  logic [1:0]            retrig_mode,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH*VAL_W-1:0] ch_min,
  input  logic [N_CH*VAL_W-1:0] ch_max,
  output logic [N_CH*VAL_W-1:0] ch_value,
  output logic                  value_valid,
  output logic                  busy,
  output logic [1:0]            env_state,
  output logic                  beat_dropped
);

  localparam int ML    = (ATTACK_LOG2 > RELEASE_LOG2) ?
                         ATTACK_LOG2 : RELEASE_LOG2;
  localparam int PW    = VAL_W + ML + 1;
  localparam int LW    = 2 * VAL_W + 1;
  localparam int PRE_W = $clog2(STEP_CLKS);
  localparam int ATT_N = 1 << ATTACK_LOG2;
  localparam int REL_N = 1 << RELEASE_LOG2;
  localparam int CMAX  = (HOLD_STEPS > (1 << ML)) ?
                         HOLD_STEPS : (1 << ML);
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int HLAST = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  typedef logic [N_CH-1:0][VAL_W-1:0] vec_t;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vec_t             val_q, val_d;
  vec_t             min_q, min_d;
  vec_t             peak_q, peak_d;
  vec_t             start_q, start_d;
  logic [N_CH-1:0]  en_q, en_d;
  logic             vv_q, vv_d;
  logic             drop_q, drop_d;

  vec_t       cmin, cmax;
  logic       busy_w, step_tick;
  logic       att_last, hold_last, rel_last, rel_done;
  logic       accept, from_cur;
  logic [ML:0] k;

  assign cmin = ch_min;
  assign cmax = ch_max;

  // Ramp from 'from' towards 'to', k/2^sh of the way, either direction.
  function automatic logic [VAL_W-1:0] ramp(
    input logic [VAL_W-1:0] from,
    input logic [VAL_W-1:0] to,
    input logic [ML:0]      kk,
    input int               sh
  );
    logic             up;
    logic [VAL_W-1:0] diff;
    logic [PW-1:0]    prod;
    logic [VAL_W-1:0] dv;
    up   = to >= from;
    diff = up ? to - from : from - to;
    prod = PW'(diff) * PW'(kk);
    dv   = VAL_W'(prod >> sh);
    return up ? from + dv : from - dv;
  endfunction

  function automatic logic [VAL_W-1:0] peak_of(
    input logic [VAL_W-1:0] lo,
    input logic [VAL_W-1:0] hi,
    input logic [VAL_W-1:0] lvl
  );
    logic [VAL_W-1:0] span;
    logic [LW-1:0]    prod;
    span = (hi > lo) ? hi - lo : '0;
    prod = LW'(span) * (LW'(lvl) + LW'(1));
    return lo + VAL_W'(prod >> VAL_W);
  endfunction

  assign busy_w    = state_q != S_IDLE;
  assign step_tick = pre_q == PRE_W'(STEP_CLKS - 1);
  assign att_last  = cnt_q == CNT_W'(ATT_N - 1);
  assign hold_last = cnt_q == CNT_W'(HLAST);
  assign rel_last  = cnt_q == CNT_W'(REL_N - 1);
  assign rel_done  = (state_q == S_RELEASE) && step_tick && rel_last;
  assign k         = (ML+1)'(cnt_q + CNT_W'(1));

  assign accept   = beat_trigger &&
                    (!busy_w || rel_done ||
                     retrig_mode == 2'd1 || retrig_mode == 2'd2);
  assign from_cur = busy_w && !rel_done && retrig_mode == 2'd1;

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    cnt_d   = cnt_q;
    val_d   = val_q;
    min_d   = min_q;
    peak_d  = peak_q;
    start_d = start_q;
    en_d    = en_q;
    vv_d    = 1'b0;
    drop_d  = beat_trigger && busy_w && !accept;
    if (busy_w && !step_tick) pre_d = pre_q + PRE_W'(1);

    if (accept) begin
      state_d = S_ATTACK;
      pre_d   = '0;
      cnt_d   = '0;
      vv_d    = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        min_d[c]   = cmin[c];
        peak_d[c]  = peak_of(cmin[c], cmax[c], beat_level);
        start_d[c] = from_cur ? val_q[c] : cmin[c];
        en_d[c]    = ch_enable[c];
        val_d[c]   = ch_enable[c] ? start_d[c] : cmin[c];
      end
    end else begin
      unique case (state_q)
        S_IDLE: val_d = cmin;
        S_ATTACK: if (step_tick) begin
          vv_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          for (int c = 0; c < N_CH; c++)
            val_d[c] = ramp(start_q[c], peak_q[c], k, ATTACK_LOG2);
          if (att_last) begin
            cnt_d   = '0;
            state_d = (HOLD_STEPS == 0) ? S_RELEASE : S_HOLD;
          end
        end
        S_HOLD: if (step_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (hold_last) begin
            cnt_d   = '0;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: if (step_tick) begin
          vv_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          for (int c = 0; c < N_CH; c++)
            val_d[c] = ramp(peak_q[c], min_q[c], k, RELEASE_LOG2);
          if (rel_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      endcase
      for (int c = 0; c < N_CH; c++)
        if (!en_q[c]) val_d[c] = cmin[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      min_q   <= '0;
      peak_q  <= '0;
      start_q <= '0;
      en_q    <= '0;
      vv_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      min_q   <= min_d;
      peak_q  <= peak_d;
      start_q <= start_d;
      en_q    <= en_d;
      vv_q    <= vv_d;
      drop_q  <= drop_d;
    end
  end

  assign ch_value     = val_q;
  assign value_valid  = vv_q;
  assign busy         = busy_w;
  assign env_state    = state_q;
  assign beat_dropped = drop_q;

endmodule
